raymarch_fb_writer: RTL and testbench
=====================================

// Module: raymarch_fb_writer
// PURPOSE
//  Downstream of the raymarcher. Captures each finished pixel (coords + 8-bit RGB),
//  packs it to RGB565 and computes the framebuffer address y*WIDTH+x.
//  Buffers results in a small FIFO and drains them to a BRAM write port with
//  valid/ready flow control. Flags end-of-frame and overflow.
// PARAMETERS
//  WIDTH       1280  frame width in pixels
//  HEIGHT      720   frame height in pixels
//  FIFO_DEPTH  8     result FIFO entries (power of 2, >=2)
// PORTS
//  clk_pixel_in     in   1                      pixel clock; only clock
//  rst_in           in   1                      synchronous, active-high reset
//  pixel_valid_in   in   1                      one-cycle strobe: pixel result valid
//  x_in             in   $clog2(WIDTH)          pixel x
//  y_in             in   $clog2(HEIGHT)         pixel y
//  red_in           in   8                      pixel red
//  green_in         in   8                      pixel green
//  blue_in          in   8                      pixel blue
//  fb_we_out        out  1                      write valid; FIFO head presented
//  fb_addr_out      out  $clog2(WIDTH*HEIGHT)   framebuffer word address
//  fb_data_out      out  16                     {R[7:3],G[7:2],B[7:3]}
//  fb_ready_in      in   1                      sink accepts write this cycle
//  frame_done_out   out  1                      1-cycle pulse after last pixel written
//  frame_count_out  out  16                     completed frames, wraps at 2^16
//  overflow_out     out  1                      sticky: a pixel was dropped
// BEHAVIOUR
//  - Reset: FIFO emptied; all outputs 0; input FSM -> SKIP_FIRST. Reset mid-drain
//    discards every queued entry; no write is issued in the reset cycle.
//  - Input FSM:
//      SKIP_FIRST: first pixel_valid_in is discarded (raymarcher's post-reset
//        pulse carries no data) -> RUN.
//      RUN: every strobe is processed; RUN is left only by reset.
//  - Pipeline:
//      Stage 1 registers x, y, color and valid.
//      Stage 2 computes addr = y*WIDTH+x and the packed color, then pushes.
//      Strobe in cycle N, FIFO empty: fb_we_out high in cycle N+2.
//  - Out-of-range coords (x>=WIDTH or y>=HEIGHT): entry not pushed, no flag.
//  - FIFO is show-ahead: fb_we_out = !empty; addr/data = head entry.
//    Transfer occurs when fb_we_out && fb_ready_in; the head pops on that edge.
//    While fb_ready_in=0, fb_we_out/addr/data are held stable.
//  - Full: push with FIFO full and no pop that cycle -> pixel dropped,
//    overflow_out<=1 until reset. Full with a simultaneous pop -> push accepted.
//  - Each entry carries a last flag = (addr == WIDTH*HEIGHT-1).
//    On transfer of a last entry: frame_done_out=1 the next cycle and
//    frame_count_out increments (wraps 0xFFFF->0).
//  - Packing truncates: R=red[7:3], G=green[7:2], B=blue[7:3].
//  - Strobes closer than 1 cycle apart are not supported (raymarcher guarantees
//    >=3 cycles).
// CONFIGURATION
//  RAYMARCH_FB_DITHER_EN defined: 2x2 ordered dither before truncation.
//    Index {y[0],x[0]}: 00->0, 01->2, 10->3, 11->1.
//    R/B add 2*value; G adds value. Add saturates at 255, then truncate.
//  Not defined: plain truncation; identical latency either way.
// TESTING
//  - Reset, then strobe (5,3,FF,80,00): discarded. Second strobe (5,3,FF,80,00):
//    fb_we_out at N+2, addr=3845, data=0xFC00.
//  - fb_ready_in=0, 9 strobes 4 cycles apart: first 8 queued, 9th dropped,
//    overflow_out=1; ready=1 drains 8 writes in order, 1/cycle.
//  - Strobe x=1279,y=719, ready=1: write addr=921599; frame_done_out pulses once;
//    frame_count_out 0->1.
//  - Strobe x=1280,y=0: no write, overflow_out stays 0.
//  - Assert rst_in with 4 entries queued: fb_we_out=0 next cycle; next strobe is
//    discarded (SKIP_FIRST).
//  - DITHER_EN, x=1,y=0, RGB=(FD,FE,FD): dithered (FF,FF,FF) -> data=0xFFFF;
//    without the macro -> 0xFFFF; RGB=(04,00,04) -> 0x0801 vs 0x0000.

Source files
------------

// File: rtl/raymarch_fb_writer.sv
// Raymarcher framebuffer writer: RGB565 pack, address gen, FIFO to BRAM port.
// Define RAYMARCH_FB_DITHER_EN for a 2x2 ordered dither ahead of truncation.
module raymarch_fb_writer #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk_pixel_in,
    input  logic                             rst_in,
    input  logic                             pixel_valid_in,
    input  logic [$clog2(WIDTH)-1:0]         x_in,
    input  logic [$clog2(HEIGHT)-1:0]        y_in,
    input  logic [7:0]                       red_in,
    input  logic [7:0]                       green_in,
    input  logic [7:0]                       blue_in,
    output logic                             fb_we_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]  fb_addr_out,
    output logic [15:0]                      fb_data_out,
    input  logic                             fb_ready_in,
    output logic                             frame_done_out,
    output logic [15:0]                      frame_count_out,
    output logic                             overflow_out
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH*HEIGHT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 17;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH*HEIGHT-1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic {SKIP_FIRST = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            s1_valid_q, s1_valid_d;
    logic [XW-1:0]   s1_x_q, s1_x_d;
    logic [YW-1:0]   s1_y_q, s1_y_d;
    logic [7:0]      s1_r_q, s1_r_d;
    logic [7:0]      s1_g_q, s1_g_d;
    logic [7:0]      s1_b_q, s1_b_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            frame_done_q, frame_done_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic [EW-1:0]   entry_d;
    logic [EW-1:0]   head;
    logic [AW-1:0]   addr;
    logic [7:0]      r_adj, g_adj, b_adj;
    logic [15:0]     pix;
    logic            in_range, push, pop, full, push_ok;
    logic            head_vld, head_last;

`ifdef RAYMARCH_FB_DITHER_EN
    function automatic logic [7:0] sat_add(input logic [7:0] a,
                                           input logic [2:0] d);
        logic [8:0] s;
        s = {1'b0, a} + {6'd0, d};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [1:0] dv;

    always_comb begin
        unique case ({s1_y_q[0], s1_x_q[0]})
            2'b00:   dv = 2'd0;
            2'b01:   dv = 2'd2;
            2'b10:   dv = 2'd3;
            default: dv = 2'd1;
        endcase
        r_adj = sat_add(s1_r_q, {dv, 1'b0});
        g_adj = sat_add(s1_g_q, {1'b0, dv});
        b_adj = sat_add(s1_b_q, {dv, 1'b0});
    end
`else
    assign r_adj = s1_r_q;
    assign g_adj = s1_g_q;
    assign b_adj = s1_b_q;
`endif

    assign head      = mem_q[rd_ptr_q];
    assign head_vld  = (count_q != '0);
    assign head_last = head[EW-1];

    // Reset gates the write strobe so nothing transfers in the reset cycle.
    assign fb_we_out       = head_vld && !rst_in;
    assign fb_addr_out     = fb_we_out ? head[EW-2 -: AW] : '0;
    assign fb_data_out     = fb_we_out ? head[15:0] : '0;
    assign frame_done_out  = frame_done_q;
    assign frame_count_out = frame_count_q;
    assign overflow_out    = overflow_q;

    always_comb begin
        state_d    = state_q;
        s1_valid_d = 1'b0;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_r_d     = s1_r_q;
        s1_g_d     = s1_g_q;
        s1_b_d     = s1_b_q;
        if (pixel_valid_in) begin
            if (state_q == SKIP_FIRST) begin
                state_d = RUN;
            end else begin
                s1_valid_d = 1'b1;
            end
            s1_x_d = x_in;
            s1_y_d = y_in;
            s1_r_d = red_in;
            s1_g_d = green_in;
            s1_b_d = blue_in;
        end
    end

    always_comb begin
        in_range = (32'(s1_x_q) < WIDTH) && (32'(s1_y_q) < HEIGHT);
        addr     = AW'(32'(s1_y_q) * WIDTH + 32'(s1_x_q));
        pix      = {5'(r_adj >> 3), 6'(g_adj >> 2), 5'(b_adj >> 3)};
        entry_d  = {addr == LAST_ADDR, addr, pix};
        push     = s1_valid_q && in_range;
        pop      = fb_we_out && fb_ready_in;
        full     = (count_q == FULL_CNT);
        push_ok  = push && (!full || pop);

        wr_ptr_d      = wr_ptr_q + PW'(push_ok);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        count_d       = count_q + CW'(push_ok) - CW'(pop);
        overflow_d    = overflow_q || (push && full && !pop);
        frame_done_d  = pop && head_last;
        frame_count_d = frame_count_q + 16'(pop && head_last);
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_q       <= SKIP_FIRST;
            s1_valid_q    <= 1'b0;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            s1_r_q        <= '0;
            s1_g_q        <= '0;
            s1_b_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            s1_valid_q    <= s1_valid_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            s1_r_q        <= s1_r_d;
            s1_g_q        <= s1_g_d;
            s1_b_q        <= s1_b_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (push_ok && !rst_in) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

endmodule

// File: tb/tb_raymarch_fb_writer.sv
// Scoreboard bench for raymarch_fb_writer: directed pixels, queued expectations,
// negedge monitor comparing every accepted framebuffer write.
module tb_raymarch_fb_writer;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        pixel_valid_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [7:0]  red_in, green_in, blue_in;
    logic        fb_we_out;
    logic [19:0] fb_addr_out;
    logic [15:0] fb_data_out;
    logic        fb_ready_in;
    logic        frame_done_out;
    logic [15:0] frame_count_out;
    logic        overflow_out;

    always #5 clk = ~clk;

    raymarch_fb_writer dut (
        .clk_pixel_in    (clk),
        .rst_in          (rst_in),
        .pixel_valid_in  (pixel_valid_in),
        .x_in            (x_in),
        .y_in            (y_in),
        .red_in          (red_in),
        .green_in        (green_in),
        .blue_in         (blue_in),
        .fb_we_out       (fb_we_out),
        .fb_addr_out     (fb_addr_out),
        .fb_data_out     (fb_data_out),
        .fb_ready_in     (fb_ready_in),
        .frame_done_out  (frame_done_out),
        .frame_count_out (frame_count_out),
        .overflow_out    (overflow_out)
    );

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    int          va [9] = '{0, 1290, 2580, 3870, 5160, 6450, 7740, 9030, 10320};
    logic [7:0]  vr [9] = '{8'hF8, 8'h00, 8'h00, 8'h08, 8'h10, 8'hF8, 8'h80, 8'h40, 8'h20};
    logic [7:0]  vg [9] = '{8'h00, 8'hFC, 8'h00, 8'h04, 8'h08, 8'hFC, 8'h80, 8'h20, 8'h20};
    logic [7:0]  vb [9] = '{8'h00, 8'h00, 8'hF8, 8'h08, 8'h10, 8'hF8, 8'h80, 8'h18, 8'h20};
    logic [15:0] vd [9] = '{16'hF800, 16'h07E0, 16'h001F, 16'h0821, 16'h1042,
                            16'hFFFF, 16'h8410, 16'h4103, 16'h0000};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int a, input logic [15:0] d);
        exp_q.push_back(wr_t'{addr: 20'(a), data: d});
    endtask

    task automatic pulse(input int x, input int y, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
        @(posedge clk);
        #1;
        pixel_valid_in = 1'b1;
        x_in           = 11'(x);
        y_in           = 10'(y);
        red_in         = r;
        green_in       = g;
        blue_in        = b;
        @(posedge clk);
        #1;
        pixel_valid_in = 1'b0;
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (fb_we_out === 1'b1 && fb_ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none",
                         fb_addr_out, fb_data_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(fb_addr_out), 32'(mon_e.addr));
                chk("wr_data", 32'(fb_data_out), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int seen;
        int at;
        rst_in         = 1'b1;
        pixel_valid_in = 1'b0;
        x_in           = '0;
        y_in           = '0;
        red_in         = '0;
        green_in       = '0;
        blue_in        = '0;
        fb_ready_in    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;

        @(negedge clk);
        chk("rst_we", 32'(fb_we_out), 0);
        chk("rst_addr", 32'(fb_addr_out), 0);
        chk("rst_data", 32'(fb_data_out), 0);
        chk("rst_frame_done", 32'(frame_done_out), 0);
        chk("rst_frame_count", 32'(frame_count_out), 0);
        chk("rst_overflow", 32'(overflow_out), 0);

        // first strobe after reset is dropped
        pulse(5, 3, 8'hFF, 8'h80, 8'h00);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (fb_we_out) seen++;
        end
        chk("skip_first", 32'(seen), 0);

        push_exp(3845, 16'hFC00);
        pulse(5, 3, 8'hFF, 8'h80, 8'h00);
        @(negedge clk);
        chk("latency_n1", 32'(fb_we_out), 0);
        @(negedge clk);
        chk("latency_n2", 32'(fb_we_out), 1);
        repeat (3) @(negedge clk);

        // out-of-range coordinates
        pulse(1280, 0, 8'hFF, 8'hFF, 8'hFF);
        gap();
        pulse(0, 720, 8'hFF, 8'hFF, 8'hFF);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (fb_we_out) seen++;
        end
        chk("range_no_write", 32'(seen), 0);
        chk("range_no_overflow", 32'(overflow_out), 0);

        // last pixel of frame
        push_exp(921599, 16'hFFFF);
        pulse(1279, 719, 8'hF8, 8'hFC, 8'hF8);
        seen = 0;
        at   = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (frame_done_out) begin
                seen++;
                at = k;
            end
        end
        chk("frame_done_pulses", 32'(seen), 1);
        chk("frame_done_cycle", 32'(at), 3);
        chk("frame_count", 32'(frame_count_out), 1);

        // fill while stalled, ninth pixel overflows
        fb_ready_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) push_exp(va[i], vd[i]);
            pulse(10 * i, i, vr[i], vg[i], vb[i]);
            if (i < 8) gap();
        end
        repeat (2) @(negedge clk);
        chk("overflow_set", 32'(overflow_out), 1);
        chk("stall_we", 32'(fb_we_out), 1);
        chk("stall_addr", 32'(fb_addr_out), 0);
        chk("stall_data", 32'(fb_data_out), 32'h0000F800);
        @(posedge clk);
        #1 fb_ready_in = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (fb_we_out) seen++;
        end
        chk("drain_burst", 32'(seen), 8);
        @(negedge clk);
        chk("drain_empty", 32'(fb_we_out), 0);
        chk("drain_queue", 32'(exp_q.size()), 0);

        // reset with entries queued
        fb_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse(i, 1, 8'h11, 8'h22, 8'h33);
            gap();
        end
        chk("queued_before_reset", 32'(fb_we_out), 1);
        @(posedge clk);
        #1 rst_in = 1'b1;
        @(negedge clk);
        chk("we_in_reset", 32'(fb_we_out), 0);
        @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        chk("we_after_reset", 32'(fb_we_out), 0);
        chk("overflow_cleared", 32'(overflow_out), 0);
        chk("count_kept_zero", 32'(frame_count_out), 0);
        fb_ready_in = 1'b1;
        pulse(5, 3, 8'hFF, 8'h80, 8'h00);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (fb_we_out) seen++;
        end
        chk("skip_after_reset", 32'(seen), 0);

        // rounding / dither corner colours
        push_exp(1, 16'hFFFF);
        pulse(1, 0, 8'hFD, 8'hFE, 8'hFD);
        gap();
`ifdef RAYMARCH_FB_DITHER_EN
        push_exp(1, 16'h0801);
`else
        push_exp(1, 16'h0000);
`endif
        pulse(1, 0, 8'h04, 8'h00, 8'h04);
        repeat (6) @(negedge clk);
        chk("all_written", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
